// File: rtl/output_uart_device.sv
`default_nettype none
// ============================================================================
// output_uart_device : memory-mapped UART TX peripheral with transmit FIFO.
// Optional even-parity bit enabled by defining OUTPUT_UART_PARITY_EN.
// Revision: 1.0
// ============================================================================
module output_uart_device #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] output_address,
  input  logic [31:0] output_out,
  input  logic [1:0]  output_size,
  input  logic        output_write_enable,
  output logic [31:0] output_in,
  output logic        tx
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam int LASTI = CLKS_PER_BIT - 1;
  localparam logic [CW-1:0] BIT_LAST = LASTI[CW-1:0];
  localparam logic [AW:0]   DEPTH_C  = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [CW-1:0] CLK_ONE  = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3
`ifdef OUTPUT_UART_PARITY_EN
    ,S_PARITY = 3'd4
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
`ifdef OUTPUT_UART_PARITY_EN
  logic            par_q, par_d;
`endif
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, w_wr_idx;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      data_q, data_d;
  logic            en_q, en_d, ovf_q, ovf_d;

  logic [3:0]  w_szmask, w_mask;
  logic [31:0] w_wdata;
  logic        w_push, w_flush, w_clr, w_ctrl_wr, w_full, w_empty, w_pop, w_accept;
  logic [7:0]  w_status, w_ctrl;
  logic [31:0] w_regs;
  logic        w_unused;

  // Bring each write lane onto its register offset so lane k hits offset addr+k.
  always_comb begin
    case (output_size)
      2'b00:   w_szmask = 4'b0001;
      2'b01:   w_szmask = 4'b0011;
      default: w_szmask = 4'b1111;
    endcase
    w_mask  = output_write_enable ? (w_szmask << output_address[1:0]) : 4'b0000;
    w_wdata = output_out << {output_address[1:0], 3'b000};
  end

  assign w_push    = w_mask[0];
  assign w_clr     = w_mask[1] & w_wdata[11];
  assign w_ctrl_wr = w_mask[2];
  assign w_flush   = w_mask[2] & w_wdata[17];
  assign w_full    = (count_q == DEPTH_C);
  assign w_empty   = (count_q == '0);
  assign w_pop     = (state_q == S_IDLE) && en_q && !w_empty;
  assign w_unused  = &{1'b0, output_address[31:2], w_wdata[31:18], w_wdata[15:12], w_wdata[10:8]};

  // Flush takes effect first, then the push, then the overflow clear.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    en_d     = en_q;
    ovf_d    = ovf_q;
    w_wr_idx = wr_ptr_q;
    w_accept = 1'b0;
    if (w_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      w_wr_idx = '0;
      if (w_push) begin
        w_accept = 1'b1;
        wr_ptr_d = PTR_ONE;
        count_d  = CNT_ONE;
      end
    end else begin
      w_accept = w_push && (!w_full || w_pop);
      if (w_pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (w_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
      case ({w_accept, w_pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      if (w_push && !w_accept) ovf_d = 1'b1;
    end
    if (w_push)    data_d = w_wdata[7:0];
    if (w_ctrl_wr) en_d   = w_wdata[16];
    if (w_clr)     ovf_d  = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef OUTPUT_UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = mem[rd_ptr_q];
`ifdef OUTPUT_UART_PARITY_EN
          par_d   = ^mem[rd_ptr_q];
`endif
        end
      end
      default: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          case (state_q)
            S_START: state_d = S_DATA;
            S_DATA: begin
              if (bit_q == 3'd7) begin
`ifdef OUTPUT_UART_PARITY_EN
                state_d = S_PARITY;
`else
                state_d = S_STOP;
`endif
              end else begin
                bit_d   = bit_q + 3'd1;
                shift_d = {1'b0, shift_q[7:1]};
              end
            end
`ifdef OUTPUT_UART_PARITY_EN
            S_PARITY: state_d = S_STOP;
`endif
            default: state_d = S_IDLE;
          endcase
        end else begin
          cnt_d = cnt_q + CLK_ONE;
        end
      end
    endcase
    // tx is registered from the next state so the line never glitches.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef OUTPUT_UART_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef OUTPUT_UART_PARITY_EN
      par_q    <= 1'b0;
`endif
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      en_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef OUTPUT_UART_PARITY_EN
      par_q    <= par_d;
`endif
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) mem[w_wr_idx] <= w_wdata[7:0];
  end

  assign w_status  = {4'b0000, ovf_q, (state_q != S_IDLE), w_empty, w_full};
  assign w_ctrl    = {7'b0000000, en_q};
  assign w_regs    = {8'(count_q), w_ctrl, w_status, data_q};
  assign output_in = w_regs >> {output_address[1:0], 3'b000};
  assign tx        = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_output_uart_device.sv
`default_nettype none
// ============================================================================
// tb_output_uart_device : scoreboard bench for output_uart_device.
// Revision: 1.0
// ============================================================================
module tb_output_uart_device;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
`ifdef OUTPUT_UART_PARITY_EN
  localparam int FRAME = 11 * CPB;
`else
  localparam int FRAME = 10 * CPB;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  size = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        tx;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [7:0] sbq [$];

  output_uart_device #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .output_address     (addr),
    .output_out         (wdata),
    .output_size        (size),
    .output_write_enable(we),
    .output_in          (rdata),
    .tx                 (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [1:0] s);
    addr = {30'b0, a};
    wdata = d;
    size = s;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = {30'b0, a};
    #1;
    v = rdata;
  endtask

  // Capture one frame; returns at the last STOP cycle.
  task automatic rx(input bit already, output logic [7:0] b, output logic p,
                    output logic s, output int st, output bit ok);
    ok = already && (tx === 1'b0);
    for (int t = 0; t < 300 && !ok; t++) begin
      tick();
      if (tx === 1'b0) ok = 1'b1;
    end
    st = cyc;
    b = '0;
    p = 1'b0;
    s = 1'b0;
    if (!ok) return;
    repeat (CPB + CPB / 2) tick();
    b[0] = tx;
    for (int j = 1; j < 8; j++) begin
      repeat (CPB) tick();
      b[j] = tx;
    end
`ifdef OUTPUT_UART_PARITY_EN
    repeat (CPB) tick();
    p = tx;
`endif
    repeat (CPB) tick();
    s = tx;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    rd(2'd0, v);
    n_cmp++; if (v !== 32'h0001_0200) begin n_err++; $display("FAIL reset_word got=%h exp=%h", v, 32'h0001_0200); end
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got=%b exp=1", tx); end
    rd(2'd1, v);
    n_cmp++; if (v !== 32'h0000_0102) begin n_err++; $display("FAIL reset_off1 got=%h exp=%h", v, 32'h0000_0102); end
    rd(2'd2, v);
    n_cmp++; if (v !== 32'h0000_0001) begin n_err++; $display("FAIL reset_off2 got=%h exp=%h", v, 32'h0000_0001); end
    rd(2'd3, v);
    n_cmp++; if (v !== 32'h0) begin n_err++; $display("FAIL reset_off3 got=%h exp=0", v); end
  endtask

  task automatic test_frame();
    logic [31:0] v;
    logic [7:0]  exp;
    logic        e_tx, e_busy;
    wr(2'd0, 32'h41, 2'b00);
    sbq.push_back(8'h41);
    rd(2'd3, v);
    n_cmp++; if (v[7:0] !== 8'd1) begin n_err++; $display("FAIL frame_count_push got=%0d exp=1", v[7:0]); end
    exp = sbq.pop_front();
    for (int i = 1; i <= FRAME + 1; i++) begin
      tick();
      rd(2'd1, v);
      if (i <= CPB)            e_tx = 1'b0;
      else if (i <= 9 * CPB)   e_tx = exp[(i - CPB - 1) / CPB];
`ifdef OUTPUT_UART_PARITY_EN
      else if (i <= 10 * CPB)  e_tx = ^exp;
`endif
      else                     e_tx = 1'b1;
      e_busy = (i <= FRAME);
      n_cmp++;
      if (tx !== e_tx || v[2] !== e_busy) begin
        n_err++;
        $display("FAIL frame_bit cycle=%0d tx=%b exp_tx=%b busy=%b exp_busy=%b", i, tx, e_tx, v[2], e_busy);
      end
    end
    rd(2'd3, v);
    n_cmp++; if (v[7:0] !== 8'd0) begin n_err++; $display("FAIL frame_count_end got=%0d exp=0", v[7:0]); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    int lows = 0;
    wr(2'd2, 32'h00, 2'b00);
    for (int k = 1; k <= 9; k++) begin
      wr(2'd0, k, 2'b00);
      if (k <= DEPTH) sbq.push_back(8'(k));
      if (tx !== 1'b1) lows++;
    end
    rd(2'd3, v);
    n_cmp++; if (v[7:0] !== 8'd8) begin n_err++; $display("FAIL ovf_count got=%0d exp=8", v[7:0]); end
    rd(2'd1, v);
    n_cmp++; if (v[7:0] !== 8'h09) begin n_err++; $display("FAIL ovf_status got=%h exp=09", v[7:0]); end
    rd(2'd0, v);
    n_cmp++; if (v[7:0] !== 8'h09) begin n_err++; $display("FAIL ovf_data got=%h exp=09", v[7:0]); end
    n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL ovf_tx_idle low_cycles=%0d exp=0", lows); end
  endtask

  task automatic test_flush();
    logic [31:0] v;
    logic [7:0]  b, exp;
    logic        p, s;
    int          st, lows;
    bit          ok;
    wr(2'd1, 32'h08, 2'b00);
    rd(2'd1, v);
    n_cmp++; if (v[7:0] !== 8'h01) begin n_err++; $display("FAIL flush_ovf_clear got=%h exp=01", v[7:0]); end
    // CTRL byte 0x02: flush with tx_enable cleared, DATA byte 0x44 pushed.
    wr(2'd0, 32'h0002_0044, 2'b10);
    sbq.delete();
    sbq.push_back(8'h44);
    rd(2'd0, v);
    n_cmp++; if (v !== 32'h0100_0044) begin n_err++; $display("FAIL flush_word got=%h exp=%h", v, 32'h0100_0044); end
    lows = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (tx !== 1'b1) lows++; end
    rd(2'd3, v);
    n_cmp++; if (v[7:0] !== 8'd1 || lows !== 0) begin n_err++; $display("FAIL flush_hold count=%0d exp=1 low_cycles=%0d exp=0", v[7:0], lows); end
    wr(2'd2, 32'h01, 2'b00);
    rx(1'b0, b, p, s, st, ok);
    exp = sbq.pop_front();
    n_cmp++; if (!ok || b !== exp || s !== 1'b1) begin n_err++; $display("FAIL flush_tx ok=%0d got=%h exp=%h stop=%b", ok, b, exp, s); end
    rd(2'd3, v);
    n_cmp++; if (v[7:0] !== 8'd0) begin n_err++; $display("FAIL flush_count_end got=%0d exp=0", v[7:0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b, exp;
    logic       p, s;
    int         st, prev;
    bit         ok;
    wr(2'd2, 32'h00, 2'b00);
    wr(2'd0, 32'hA5, 2'b00); sbq.push_back(8'hA5);
    wr(2'd0, 32'h3C, 2'b00); sbq.push_back(8'h3C);
    wr(2'd0, 32'hFF, 2'b00); sbq.push_back(8'hFF);
    wr(2'd2, 32'h01, 2'b00);
    prev = 0;
    for (int f = 0; f < 3; f++) begin
      rx(1'b0, b, p, s, st, ok);
      exp = sbq.pop_front();
      n_cmp++; if (!ok || b !== exp || s !== 1'b1) begin n_err++; $display("FAIL b2b_byte%0d ok=%0d got=%h exp=%h stop=%b", f, ok, b, exp, s); end
      if (f > 0) begin
        n_cmp++; if (st - prev !== FRAME + 1) begin n_err++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", f, st - prev, FRAME + 1); end
      end
      prev = st;
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] v;
    logic [7:0]  b, exp;
    logic        p, s;
    int          st;
    bit          ok;
    wr(2'd2, 32'h00, 2'b00);
    for (int k = 0; k < DEPTH; k++) begin
      wr(2'd0, 32'h10 + k, 2'b00);
      sbq.push_back(8'(8'h10 + k));
    end
    wr(2'd2, 32'h01, 2'b00);
    wr(2'd0, 32'h18, 2'b00);
    sbq.push_back(8'h18);
    rd(2'd3, v);
    n_cmp++; if (v[7:0] !== 8'd8) begin n_err++; $display("FAIL fullpp_count got=%0d exp=8", v[7:0]); end
    rd(2'd1, v);
    n_cmp++; if (v[7:0] !== 8'h05) begin n_err++; $display("FAIL fullpp_status got=%h exp=05", v[7:0]); end
    for (int f = 0; f <= DEPTH; f++) begin
      rx(f == 0, b, p, s, st, ok);
      exp = sbq.pop_front();
      n_cmp++; if (!ok || b !== exp || s !== 1'b1) begin n_err++; $display("FAIL fullpp_byte%0d ok=%0d got=%h exp=%h stop=%b", f, ok, b, exp, s); end
    end
    tick();
    rd(2'd1, v);
    n_cmp++; if (v[7:0] !== 8'h02) begin n_err++; $display("FAIL fullpp_idle got=%h exp=02", v[7:0]); end
  endtask

  task automatic test_parity();
    logic [31:0] v;
    logic [7:0]  b, exp;
    logic        p, s;
    int          st;
    bit          ok;
    wr(2'd0, 32'h07, 2'b00);
    sbq.push_back(8'h07);
    rx(1'b0, b, p, s, st, ok);
    exp = sbq.pop_front();
    n_cmp++; if (!ok || b !== exp || s !== 1'b1) begin n_err++; $display("FAIL par_byte ok=%0d got=%h exp=%h stop=%b", ok, b, exp, s); end
`ifdef OUTPUT_UART_PARITY_EN
    n_cmp++; if (p !== ^exp) begin n_err++; $display("FAIL par_bit got=%b exp=%b", p, ^exp); end
`endif
    rd(2'd1, v);
    n_cmp++; if (v[2] !== 1'b1) begin n_err++; $display("FAIL par_last_stop_busy got=%b exp=1", v[2]); end
    tick();
    rd(2'd1, v);
    n_cmp++; if (v[7:0] !== 8'h02) begin n_err++; $display("FAIL par_frame_end got=%h exp=02", v[7:0]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    int lows;
    wr(2'd0, 32'h55, 2'b00);
    sbq.push_back(8'h55);
    repeat (CPB + 3) tick();
    rd(2'd1, v);
    n_cmp++; if (v[2] !== 1'b1) begin n_err++; $display("FAIL rstmid_busy got=%b exp=1", v[2]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sbq.delete();
    n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
    rd(2'd0, v);
    n_cmp++; if (v !== 32'h0001_0200) begin n_err++; $display("FAIL rstmid_regs got=%h exp=%h", v, 32'h0001_0200); end
    lows = 0;
    for (int i = 0; i < 60; i++) begin tick(); if (tx !== 1'b1) lows++; end
    n_cmp++; if (lows !== 0) begin n_err++; $display("FAIL rstmid_no_frame low_cycles=%0d exp=0", lows); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overflow();
    test_flush();
    test_back_to_back();
    test_full_push_pop();
    test_parity();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
